// File: rtl/apb_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// apb_arb_pkg
//   Shared types for the two-requester APB command-port arbiter.
//   - state_e    : arbiter FSM states
//   - arb_cmd_t  : one captured downstream command {write, addr, wdata}
//   - NUM_REQ    : number of requesters sharing the port
//   - pick_winner: grant selection for the IDLE state
//   CMD_ADDR_W / CMD_DATA_W are the widest address/data the command struct
//   carries; the top narrows them to its own ADDR_W / DATA_W.
// -----------------------------------------------------------------------------
package apb_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } arb_cmd_t;

    // Winner among pending requesters. A lone requester always wins; on a tie
    // fixed priority favours m0, round-robin favours whoever did not go last.
    function automatic logic pick_winner(input logic [NUM_REQ-1:0] pend,
                                         input logic               last_grant,
                                         input logic               fixed_prio);
        if (pend[0] && pend[1])
            return fixed_prio ? 1'b0 : ~last_grant;
        return pend[1] && !pend[0];
    endfunction

endpackage

// File: rtl/arb_req_slot.sv
// -----------------------------------------------------------------------------
// arb_req_slot
//   Holds one requester's pending command until the arbiter retires it.
//   Ports:
//     clk_i, rst_ni : clock, synchronous active-low reset
//     set_i         : requester transfer pulse
//     cmd_i         : command sampled with set_i
//     clr_i         : arbiter retires this slot (DONE edge)
//     pend_o        : slot holds a command
//     cmd_o         : held command
//     ovf_o         : request arrived while slot was busy and not retiring
//                     (request dropped this cycle)
// -----------------------------------------------------------------------------
module arb_req_slot
    import apb_arb_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     set_i,
    input  arb_cmd_t cmd_i,
    input  logic     clr_i,
    output logic     pend_o,
    output arb_cmd_t cmd_o,
    output logic     ovf_o
);

    logic     pend_q, pend_d;
    arb_cmd_t cmd_q, cmd_d;
    logic     accept;

    // A request landing on the retiring edge is accepted: set wins over clear.
    assign accept = set_i && (!pend_q || clr_i);

    always_comb begin
        pend_d = pend_q;
        cmd_d  = cmd_q;
        if (accept) begin
            pend_d = 1'b1;
            cmd_d  = cmd_i;
        end else if (clr_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_q <= 1'b0;
            cmd_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cmd_q  <= cmd_d;
        end
    end

    assign pend_o = pend_q;
    assign cmd_o  = cmd_q;
    assign ovf_o  = set_i && pend_q && !clr_i;

endmodule

// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
//   Shares one APB_Master command port between requester m0 (core data port)
//   and m1 (DMA/debug). Each transfer pulse is parked in a slot, one winner is
//   issued downstream at a time, and read data plus a ready pulse go back to
//   that winner only.
//   Ports:
//     PCLK, PRESET           : clock, synchronous active-low reset
//     mX_transfer/write/addr/wdata : requester command (sampled with transfer)
//     mX_ready, mX_rdata     : completion pulse, read data (held after ready)
//     transfer/write/addr/wdata : downstream command to APB_Master
//     ready, rdata           : downstream completion, read data
//     grant                  : requester owning the downstream port
//     busy                   : FSM not idle
//     ovf_err                : sticky, a request hit an occupied slot
//   Every output is a register or a decode of registered state.
// -----------------------------------------------------------------------------
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,   // must not exceed CMD_ADDR_W
    parameter int DATA_W    = 32,   // must not exceed CMD_DATA_W
    parameter int PRIO_MODE = 0     // 0 round-robin, 1 fixed (m0 wins ties)
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              m0_transfer,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_transfer,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              transfer,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              ready,
    input  logic [DATA_W-1:0] rdata,
    output logic              grant,
    output logic              busy,
    output logic              ovf_err
);

    state_e                          state_q, state_d;
    logic                            grant_q, grant_d;
    logic                            last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0][DATA_W-1:0]  rdata_q;
    logic                            ovf_err_q;

    logic     [NUM_REQ-1:0]          req_xfer;
    arb_cmd_t [NUM_REQ-1:0]          req_cmd;
    logic     [NUM_REQ-1:0]          pend;
    logic     [NUM_REQ-1:0]          slot_clr;
    logic     [NUM_REQ-1:0]          slot_ovf;
    arb_cmd_t [NUM_REQ-1:0]          slot_cmd;
    arb_cmd_t                        gnt_cmd;

    assign req_xfer = {m1_transfer, m0_transfer};

    assign req_cmd[0].write = m0_write;
    assign req_cmd[0].addr  = CMD_ADDR_W'(m0_addr);
    assign req_cmd[0].wdata = CMD_DATA_W'(m0_wdata);
    assign req_cmd[1].write = m1_write;
    assign req_cmd[1].addr  = CMD_ADDR_W'(m1_addr);
    assign req_cmd[1].wdata = CMD_DATA_W'(m1_wdata);

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        // Retire on the edge that leaves DONE for this requester.
        assign slot_clr[g] = (state_q == DONE) && (grant_q == 1'(g));

        arb_req_slot u_slot (
            .clk_i  (PCLK),
            .rst_ni (PRESET),
            .set_i  (req_xfer[g]),
            .cmd_i  (req_cmd[g]),
            .clr_i  (slot_clr[g]),
            .pend_o (pend[g]),
            .cmd_o  (slot_cmd[g]),
            .ovf_o  (slot_ovf[g])
        );
    end

    // The granted slot cannot be overwritten while it is pending, so its
    // command is stable for the whole ISSUE/WAIT window.
    assign gnt_cmd = slot_cmd[grant_q];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge PCLK) begin
        if (!PRESET) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (|pend) begin
                    grant_d = pick_winner(pend, last_grant_q, PRIO_MODE == 1);
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT:  if (ready) state_d = DONE;
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        transfer = 1'b0;
        write    = 1'b0;
        addr     = '0;
        wdata    = '0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        unique case (state_q)
            ISSUE, WAIT: begin
                transfer = (state_q == ISSUE);
                write    = gnt_cmd.write;
                addr     = gnt_cmd.addr[ADDR_W-1:0];
                wdata    = gnt_cmd.wdata[DATA_W-1:0];
            end
            DONE: begin
                m0_ready = !grant_q;
                m1_ready = grant_q;
            end
            default: ;
        endcase
    end

    // ---------------- grant / rdata / error registers ----------------
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;   // m0 takes the first round-robin tie
            rdata_q      <= '0;
            ovf_err_q    <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            // Writes capture rdata too; only the winner's register moves.
            if (state_q == WAIT && ready)
                rdata_q[grant_q] <= rdata;
            ovf_err_q    <= ovf_err_q | (|slot_ovf);
        end
    end

    assign m0_rdata = rdata_q[0];
    assign m1_rdata = rdata_q[1];
    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);
    assign ovf_err  = ovf_err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic        m0_transfer = 1'b0, m0_write = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m1_transfer = 1'b0, m1_write = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic        ready = 1'b0;
    logic [31:0] rdata = '0;

    logic        m0_ready, m1_ready, transfer, write, grant, busy, ovf_err;
    logic [31:0] m0_rdata, m1_rdata, addr, wdata;

    logic        p_m0_ready, p_m1_ready, p_transfer, p_write, p_grant, p_busy, p_ovf_err;
    logic [31:0] p_m0_rdata, p_m1_rdata, p_addr, p_wdata;

    always #5 PCLK = ~PCLK;

    apb_req_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(0)) u_dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .m0_transfer(m0_transfer), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_transfer(m1_transfer), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata),
        .grant(grant), .busy(busy), .ovf_err(ovf_err)
    );

    // Fixed-priority instance fed identically; only its grant order is checked.
    apb_req_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(1)) u_prio (
        .PCLK(PCLK), .PRESET(PRESET),
        .m0_transfer(m0_transfer), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(p_m0_ready), .m0_rdata(p_m0_rdata),
        .m1_transfer(m1_transfer), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(p_m1_ready), .m1_rdata(p_m1_rdata),
        .transfer(p_transfer), .write(p_write), .addr(p_addr), .wdata(p_wdata),
        .ready(ready), .rdata(rdata),
        .grant(p_grant), .busy(p_busy), .ovf_err(p_ovf_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    // ---------------- downstream APB_Master model ----------------
    int          lat = 2;
    int          cnt = -1;
    bit          use_addr = 1'b0;
    logic [31:0] rsp_data = '0;
    logic [31:0] rsp_val = '0;

    always @(posedge PCLK) begin
        #2;
        ready = 1'b0;
        if (!PRESET) cnt = -1;
        else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ready = 1'b1;
                    rdata = rsp_val;
                end
            end
            if (transfer) begin
                cnt     = lat;
                rsp_val = use_addr ? (addr ^ 32'h5A5A_0000) : rsp_data;
            end
        end
    end

    // ---------------- monitors ----------------
    int          cyc = 0;
    int          xfer_n = 0;
    int          r0_n = 0;
    logic        xg_q[$];
    logic        pg_q[$];
    logic [31:0] xa_q[$];
    int          xc_q[$];

    always @(posedge PCLK) cyc++;

    always @(negedge PCLK) begin
        if (transfer) begin
            xfer_n++;
            xg_q.push_back(grant);
            xa_q.push_back(addr);
            xc_q.push_back(cyc);
        end
        if (p_transfer) pg_q.push_back(p_grant);
        if (m0_ready) r0_n++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic set0(input logic w, input logic [31:0] a, input logic [31:0] d);
        m0_write = w; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set1(input logic w, input logic [31:0] a, input logic [31:0] d);
        m1_write = w; m1_addr = a; m1_wdata = d;
    endtask

    // One-cycle pulse starting now (just after a posedge), ends after next edge.
    task automatic fire(input logic p0, input logic p1);
        m0_transfer = p0; m1_transfer = p1;
        @(posedge PCLK); #1;
        m0_transfer = 1'b0; m1_transfer = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge PCLK); #1 PRESET = 1'b0;
        @(posedge PCLK); #1 PRESET = 1'b1;
    endtask

    task automatic wait_rdy(input int which, input int budget, output int n);
        logic r;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
            r = which ? m1_ready : m0_ready;
        end while (!r && n < budget);
        if (!r) chk("rdy_timeout", r, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n, bx, bp, br;
        logic r;

        // ---- reset state ----
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b1;
        @(negedge PCLK);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_xfer", transfer, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_addr", addr, 0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 0);

        // ---- single write from m0, ready 2 cycles after transfer ----
        @(posedge PCLK); #1;
        set0(1'b1, 32'h1000_0000, 32'h0000_00A5);
        fire(1'b1, 1'b0);
        @(negedge PCLK); chk("wr_t1_xfer", transfer, 0);
        @(negedge PCLK);
        chk("wr_t2_xfer", transfer, 1);
        chk("wr_t2_addr", addr, 32'h1000_0000);
        chk("wr_t2_wdata", wdata, 32'h0000_00A5);
        chk("wr_t2_write", write, 1);
        chk("wr_t2_grant", grant, 0);
        chk("wr_t2_busy", busy, 1);
        @(negedge PCLK);
        chk("wr_wait_xfer", transfer, 0);
        chk("wr_wait_addr", addr, 32'h1000_0000);
        @(negedge PCLK); chk("wr_rdy_early", m0_ready, 0);
        @(negedge PCLK);
        chk("wr_m0_ready", m0_ready, 1);
        chk("wr_m1_ready", m1_ready, 0);
        @(negedge PCLK);
        chk("wr_ready_pulse", m0_ready, 0);
        chk("wr_idle", busy, 0);
        chk("wr_m1_rdata", m1_rdata, 0);

        // ---- single read from m1 ----
        rsp_data = 32'h0000_00C3;
        @(posedge PCLK); #1;
        set1(1'b0, 32'h1000_1000, 32'h0);
        fire(1'b0, 1'b1);
        wait_rdy(1, 20, n);
        chk("rd_latency", n, 5);
        chk("rd_m1_rdata", m1_rdata, 32'h0000_00C3);
        chk("rd_m0_ready", m0_ready, 0);
        chk("rd_m0_rdata", m0_rdata, 0);
        @(negedge PCLK);
        chk("rd_m1_hold", m1_rdata, 32'h0000_00C3);
        chk("rd_m1_pulse", m1_ready, 0);

        // ---- simultaneous requests after reset ----
        use_addr = 1'b1;
        do_reset();
        bx = xfer_n; bp = pg_q.size();
        set0(1'b1, 32'h2000_0000, 32'h11);
        set1(1'b0, 32'h2000_0004, 32'h0);
        fire(1'b1, 1'b1);
        wait_rdy(1, 40, n);
        chk("tie1_count", xfer_n - bx, 2);
        chk("tie1_first", xg_q[bx], 0);
        chk("tie1_second", xg_q[bx+1], 1);
        chk("tie1_spacing", xc_q[bx+1] - xc_q[bx], 5);
        chk("tie1_prio_first", pg_q[bp], 0);
        chk("tie1_m0_rdata", m0_rdata, 32'h7A5A_0000);
        chk("tie1_m1_rdata", m1_rdata, 32'h7A5A_0004);

        @(posedge PCLK); #1;
        bx = xfer_n; bp = pg_q.size();
        set0(1'b0, 32'h2000_0100, 32'h0);
        set1(1'b0, 32'h2000_0104, 32'h0);
        fire(1'b1, 1'b1);
        wait_rdy(1, 40, n);
        chk("tie2_first", xg_q[bx], 0);
        chk("tie2_second", xg_q[bx+1], 1);
        chk("tie2_prio_first", pg_q[bp], 0);

        // m0 alone leaves last_grant = 0, so the next tie splits the modes.
        @(posedge PCLK); #1;
        fire(1'b1, 1'b0);
        wait_rdy(0, 20, n);
        @(posedge PCLK); #1;
        bx = xfer_n; bp = pg_q.size();
        set0(1'b0, 32'h2000_0200, 32'h0);
        set1(1'b0, 32'h2000_0204, 32'h0);
        fire(1'b1, 1'b1);
        wait_rdy(0, 40, n);
        chk("tie3_rr_first", xg_q[bx], 1);
        chk("tie3_rr_second", xg_q[bx+1], 0);
        chk("tie3_prio_first", pg_q[bp], 0);
        chk("tie3_prio_second", pg_q[bp+1], 1);
        chk("tie3_m1_rdata", m1_rdata, 32'h7A5A_0204);

        // ---- overflow ----
        do_reset();
        @(negedge PCLK); chk("ovf_rst", ovf_err, 0);
        @(posedge PCLK); #1;
        bx = xfer_n;
        set0(1'b1, 32'h3000_0000, 32'h1);
        fire(1'b1, 1'b0);
        set0(1'b1, 32'h3000_0010, 32'h2);
        fire(1'b1, 1'b0);
        wait_rdy(0, 20, n);
        repeat (4) @(negedge PCLK);
        chk("ovf_one_xfer", xfer_n - bx, 1);
        chk("ovf_addr", xa_q[bx], 32'h3000_0000);
        chk("ovf_flag", ovf_err, 1);
        @(posedge PCLK); #1;
        set1(1'b0, 32'h3000_0030, 32'h0);
        fire(1'b0, 1'b1);
        wait_rdy(1, 20, n);
        chk("ovf_sticky", ovf_err, 1);

        // ---- set-over-clear: re-request during DONE ----
        do_reset();
        bx = xfer_n;
        set0(1'b0, 32'h3000_0020, 32'h0);
        fire(1'b1, 1'b0);
        wait_rdy(0, 20, n);
        set0(1'b0, 32'h3000_0040, 32'h0);
        m0_transfer = 1'b1;
        @(posedge PCLK); #1 m0_transfer = 1'b0;
        wait_rdy(0, 20, n);
        chk("soc_latency", n, 5);
        chk("soc_count", xfer_n - bx, 2);
        chk("soc_addr", xa_q[bx+1], 32'h3000_0040);
        chk("soc_no_ovf", ovf_err, 0);
        chk("soc_rdata", m0_rdata, 32'h6A5A_0040);

        // ---- reset mid-WAIT ----
        @(negedge PCLK);
        lat = 10;
        @(posedge PCLK); #1;
        set0(1'b1, 32'h4000_0008, 32'h77);
        fire(1'b1, 1'b0);
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
            r = transfer;
        end while (!r && n < 10);
        if (!r) chk("mid_xfer_timeout", r, 1);
        @(negedge PCLK);
        chk("mid_in_wait", busy, 1);
        br = r0_n;
        @(posedge PCLK); #1 PRESET = 1'b0;
        @(posedge PCLK); #1 PRESET = 1'b1;
        @(negedge PCLK);
        chk("mid_busy", busy, 0);
        chk("mid_xfer", transfer, 0);
        chk("mid_addr", addr, 0);
        chk("mid_wdata", wdata, 0);
        chk("mid_m0_rdata", m0_rdata, 0);
        repeat (15) @(negedge PCLK);
        chk("mid_no_ready", r0_n - br, 0);
        chk("mid_still_idle", busy, 0);
        lat = 2;
        @(posedge PCLK); #1;
        set0(1'b0, 32'h4000_0000, 32'h0);
        fire(1'b1, 1'b0);
        wait_rdy(0, 20, n);
        chk("mid_fresh_lat", n, 5);
        chk("mid_fresh_rdata", m0_rdata, 32'h1A5A_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares the single internal APB_Master command port (transfer/ready/addr/wdata/write/rdata) between two requesters: m0 (RV32I core data port) and m1 (DMA/debug engine).
- Captures each requester's one-cycle transfer pulse into a pending slot, arbitrates, issues exactly one downstream transfer at a time, and returns read data and a ready pulse to the winning requester.
- Sits between the requesters and the APB_Master instance in the MCU.

Parameters:
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all wdata/rdata ports
- PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority (m0 always wins ties)

Ports:
- PCLK  in  1  clock
- PRESET  in  1  synchronous, active-low reset
- m0_transfer / m1_transfer  in  1  one-cycle request pulse
- m0_write / m1_write  in  1  1 = write, 0 = read; sampled with transfer
- m0_addr / m1_addr  in  ADDR_W  request address; sampled with transfer
- m0_wdata / m1_wdata  in  DATA_W  write data; sampled with transfer
- m0_ready / m1_ready  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  DATA_W  read data; valid with ready, held afterwards
- transfer  out  1  downstream request pulse to APB_Master
- write  out  1  downstream direction
- addr  out  ADDR_W  downstream address
- wdata  out  DATA_W  downstream write data
- ready  in  1  downstream completion pulse from APB_Master
- rdata  in  DATA_W  downstream read data, valid with ready
- grant  out  1  requester currently owning the downstream port
- busy  out  1  state != IDLE
- ovf_err  out  1  sticky; a requester pulsed transfer while its slot was already pending

Behaviour:
- Reset (PRESET == 0 at a PCLK edge) clears the following:
  - all outputs, slots, rdata registers and ovf_err go to 0
  - state goes to IDLE
  - last_grant goes to 1, so m0 wins the first tie
- Slot i: on mi_transfer == 1, latch {write, addr, wdata} and set pend_i.
- pend_i clears on the edge that ends DONE for requester i.
- A new mi_transfer in that same cycle re-sets pend_i; set wins over clear.
- mi_transfer while pend_i == 1 and not clearing: request dropped, slot unchanged, ovf_err <= 1. ovf_err clears only on reset.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - if pend_0 | pend_1, select a winner, register it to grant and go to ISSUE
  - round-robin: if both are pending, pick !last_grant
  - PRIO_MODE = 1: pick m0 whenever pend_0
- ISSUE (exactly 1 cycle):
  - transfer = 1; write/addr/wdata driven from the granted slot
  - next state WAIT
- WAIT:
  - transfer = 0; addr/write/wdata remain driven from the granted slot
  - on ready == 1: capture rdata into m{grant}_rdata (reads and writes alike) and go to DONE
  - no timeout; WAIT holds indefinitely
  - ready while in IDLE/ISSUE/DONE is ignored
- DONE (1 cycle):
  - m{grant}_ready = 1; clear that pend; last_grant <= grant
  - next state IDLE
- Latency with no contention:
  - mi_transfer at cycle T; slot set at T+1 (IDLE); transfer high in cycle T+2
  - ready at cycle R gives mi_ready high in cycle R+1
  - back-to-back throughput: one transaction per (downstream latency + 3) cycles
- The non-granted requester's rdata and ready are untouched during the other's transaction.
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.
- Reset mid-transaction: pending requests are lost and no ready is returned. The downstream APB_Master must share PRESET.

Decomposition:
- Package apb_arb_pkg:
  - state_e enum {IDLE, ISSUE, WAIT, DONE}
  - arb_cmd_t struct {write, addr[ADDR_W], wdata[DATA_W]}
  - localparam NUM_REQ = 2
- Sub-module arb_req_slot:
  - holds one pending command: capture, pend flag, set-over-clear rule and overflow detect
  - instantiated twice
- The top level holds the FSM, the grant/last_grant logic and the rdata registers.

Test Plan:
- Single write: m0 write addr 0x1000_0000, wdata 0xA5; APB ready after 2 cycles -> transfer in T+2 with addr 0x1000_0000 / wdata 0xA5 / write = 1; m0_ready 1 cycle after ready; m1 untouched.
- Single read: m1 read addr 0x1000_1000; ready with rdata 0x0000_00C3 -> m1_rdata = 0xC3 with m1_ready and held afterwards; m0_rdata stays 0.
- Simultaneous first requests after reset, round-robin: m0 and m1 pulse together -> m0 granted first, m1 second. Repeat the pair -> order m0, m1 (last_grant alternates); with PRIO_MODE = 1, m0 always first.
- Overflow: m0 pulses twice before completion -> second request dropped, ovf_err = 1 sticky, exactly one downstream transfer. Set-over-clear: pulse m0 in its DONE cycle -> a second transaction issues.
- Reset mid-WAIT: drop PRESET for 1 cycle -> all outputs 0, state IDLE, no mi_ready; a fresh request afterwards completes normally.
